// File: rtl/icache_direct_if.sv
// Fetch-side and RAM-controller-side signals of the direct-mapped instruction cache.
// master = environment (fetch stage + RAM controller), slave = the cache.
interface icache_direct_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  if_req;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic                  if_flush;
    logic                  inv_all;
    logic                  if_valid;
    logic [31:0]           if_data;
    logic                  inst_read;
    logic [ADDR_WIDTH-1:0] inst_addr;
    logic                  inst_done;
    logic [31:0]           inst_data;

    modport master (
        output if_req, if_addr, if_flush, inv_all, inst_done, inst_data,
        input  if_valid, if_data, inst_read, inst_addr
    );

    modport slave (
        input  if_req, if_addr, if_flush, inv_all, inst_done, inst_data,
        output if_valid, if_data, inst_read, inst_addr
    );
endinterface

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache, one 32-bit word per line.
// Hits answer combinationally; misses fetch one word and forward it on arrival.
module icache_direct #(
    parameter int INDEX_BITS = 6,
    parameter int ADDR_WIDTH = 32
) (
    input logic             clk,
    input logic             rst,
    icache_direct_if.slave  bus
);
    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = ADDR_WIDTH - INDEX_BITS - 2;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t                 state, state_nx;
    logic [LINES-1:0]       valid;
    logic [TAG_W-1:0]       tag_arr  [LINES];
    logic [31:0]            data_arr [LINES];
    logic [ADDR_WIDTH-1:0]  miss_addr;

    logic [INDEX_BITS-1:0]  req_idx, miss_idx;
    logic [TAG_W-1:0]       req_tag, miss_tag;
    logic                   lookup_hit;
    logic                   start_miss;
    logic                   fill;
    logic                   unused_low_bits;

    assign req_idx  = bus.if_addr[INDEX_BITS+1:2];
    assign req_tag  = bus.if_addr[ADDR_WIDTH-1:INDEX_BITS+2];
    assign miss_idx = miss_addr[INDEX_BITS+1:2];
    assign miss_tag = miss_addr[ADDR_WIDTH-1:INDEX_BITS+2];
    assign unused_low_bits = ^bus.if_addr[1:0];

    // A flush or invalidate in the lookup cycle kills the hit outright.
    assign lookup_hit = bus.if_req & valid[req_idx] & (tag_arr[req_idx] == req_tag)
                      & ~bus.if_flush & ~bus.inv_all;

    always_comb begin
        state_nx      = state;
        bus.if_valid  = 1'b0;
        bus.if_data   = 32'd0;
        bus.inst_read = 1'b0;
        bus.inst_addr = '0;
        start_miss    = 1'b0;
        fill          = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (lookup_hit) begin
                        bus.if_valid = 1'b1;
                        bus.if_data  = data_arr[req_idx];
                    end else if (bus.if_req && !bus.if_flush && !bus.inv_all) begin
                        start_miss = 1'b1;
                        state_nx   = FETCH;
                    end
                end
                FETCH: begin
                    // Drop the request in the done cycle so the controller sees it once.
                    bus.inst_read = ~bus.inst_done;
                    bus.inst_addr = miss_addr;
                    if (bus.inst_done) begin
                        fill         = 1'b1;
                        bus.if_valid = ~bus.if_flush;
                        bus.if_data  = bus.if_flush ? 32'd0 : bus.inst_data;
                        state_nx     = IDLE;
                    end else if (bus.if_flush) begin
                        state_nx = DRAIN;
                    end
                end
                DRAIN: begin
                    // The controller cannot abort; wait out the read and keep the word.
                    bus.inst_read = ~bus.inst_done;
                    bus.inst_addr = miss_addr;
                    if (bus.inst_done) begin
                        fill     = 1'b1;
                        state_nx = IDLE;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            valid     <= '0;
            miss_addr <= '0;
        end else begin
            state <= state_nx;
            if (start_miss)
                miss_addr <= {bus.if_addr[ADDR_WIDTH-1:2], 2'b00};
            if (bus.inv_all)
                valid <= '0;
            // Later assignment wins: a fill coinciding with inv_all stays invalid.
            if (fill)
                valid[miss_idx] <= ~bus.inv_all;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && fill) begin
            tag_arr[miss_idx]  <= miss_tag;
            data_arr[miss_idx] <= bus.inst_data;
        end
    end
endmodule

// File: tb/tb_icache_direct.sv
// Self-checking bench for icache_direct: directed scenarios plus randomized
// accesses compared against a word-address-level cache model and a memory function.
module tb_icache_direct;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    icache_direct_if #(.ADDR_WIDTH(32)) ifc();
    icache_direct #(.INDEX_BITS(6), .ADDR_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .bus(ifc.slave)
    );

    always #5 clk = ~clk;

    // Memory contents: explicit overrides, otherwise a hash of the word address.
    logic [31:0] ovr [logic [31:0]];
    function automatic logic [31:0] mem_word(logic [31:0] wa);
        if (ovr.exists(wa)) return ovr[wa];
        return (wa * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    // Model: which word address each of the 64 lines currently holds, if any.
    bit          m_v  [64];
    logic [31:0] m_wa [64];

    function automatic int line_of(logic [31:0] a);
        return int'((a >> 2) % 64);
    endfunction

    function automatic bit model_hit(logic [31:0] a);
        logic [31:0] wa;
        wa = {a[31:2], 2'b00};
        return m_v[line_of(a)] && (m_wa[line_of(a)] == wa);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 64; i++) m_v[i] = 1'b0;
    endtask

    task automatic model_fill(input logic [31:0] a, input bit inv);
        if (inv) model_clear();
        m_wa[line_of(a)] = {a[31:2], 2'b00};
        m_v[line_of(a)]  = !inv;
    endtask

    task automatic idle_inputs();
        ifc.if_req = 0; ifc.if_addr = 0; ifc.if_flush = 0; ifc.inv_all = 0;
        ifc.inst_done = 0; ifc.inst_data = 0;
    endtask

    // One fetch: request, then if it missed, play the RAM controller returning the
    // word after lat cycles. flush_c = cycle of if_flush (0 = none). ok collects
    // protocol checks (inst_read/inst_addr shape, if_data=0 when not valid).
    task automatic access(input logic [31:0] addr, input int lat, input int flush_c,
                          input bit inv_done, output bit hit, output bit got_v,
                          output logic [31:0] got_d, output bit ok);
        logic [31:0] wa;
        bit done;
        wa = {addr[31:2], 2'b00};
        ok = 1; got_v = 0; got_d = 0;
        @(negedge clk);
        ifc.if_req = 1; ifc.if_addr = addr;
        #1;
        hit = ifc.if_valid;
        if (ifc.inst_read !== 1'b0) ok = 0;
        if (hit) begin got_v = 1; got_d = ifc.if_data; end
        else if (ifc.if_data !== 32'd0) ok = 0;
        if (!hit) begin
            for (int c = 1; c <= lat; c++) begin
                @(negedge clk);
                done = (c == lat);
                ifc.inst_done = done;
                ifc.inst_data = done ? mem_word(wa) : $urandom;
                ifc.if_flush  = (c == flush_c);
                ifc.inv_all   = inv_done && done;
                if (flush_c != 0 && c > flush_c) ifc.if_req = 0;
                #1;
                if (ifc.inst_read !== !done || ifc.inst_addr !== wa) ok = 0;
                if (!done && ifc.if_valid !== 1'b0) ok = 0;
                if (done && ifc.if_valid === 1'b1) begin got_v = 1; got_d = ifc.if_data; end
                if (ifc.if_valid !== 1'b1 && ifc.if_data !== 32'd0) ok = 0;
            end
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic pulse_inv(input bit with_req, input logic [31:0] addr, output bit v, output bit rd);
        @(negedge clk);
        ifc.inv_all = 1; ifc.if_req = with_req; ifc.if_addr = addr;
        #1;
        v = ifc.if_valid;
        @(negedge clk);
        idle_inputs();
        #1;
        rd = ifc.inst_read;
        model_clear();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
        #1;
        n_checks++;
        if (ifc.if_valid !== 0 || ifc.if_data !== 0 || ifc.inst_read !== 0 || ifc.inst_addr !== 0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b d=%h rd=%b a=%h required all zero",
                     ifc.if_valid, ifc.if_data, ifc.inst_read, ifc.inst_addr);
        end
        model_clear();
    endtask

    task automatic test_cold_miss_hit();
        bit hit, v, ok; logic [31:0] d;
        ovr[32'h10] = 32'h0000_0013;
        access(32'h10, 4, 0, 0, hit, v, d, ok);
        model_fill(32'h10, 0);
        n_checks++;
        if (hit !== 0 || v !== 1 || d !== 32'h13 || ok !== 1) begin
            n_fail++;
            $display("FAIL cold_miss: got hit=%b v=%b d=%h ok=%b required 0 1 00000013 1", hit, v, d, ok);
        end
        access(32'h10, 4, 0, 0, hit, v, d, ok);
        n_checks++;
        if (hit !== 1 || d !== 32'h13 || ok !== 1) begin
            n_fail++;
            $display("FAIL repeat_hit: got hit=%b d=%h ok=%b required 1 00000013 1", hit, d, ok);
        end
    endtask

    task automatic test_conflict();
        bit hit, v, ok; logic [31:0] d;
        ovr[32'h000] = 32'hAAAA_AAAA;
        ovr[32'h100] = 32'hBBBB_BBBB;
        access(32'h000, 2, 0, 0, hit, v, d, ok);
        model_fill(32'h000, 0);
        n_checks++;
        if (hit !== 0 || d !== 32'hAAAA_AAAA || ok !== 1) begin
            n_fail++;
            $display("FAIL fill_000: got hit=%b d=%h ok=%b required 0 aaaaaaaa 1", hit, d, ok);
        end
        access(32'h100, 3, 0, 0, hit, v, d, ok);
        model_fill(32'h100, 0);
        n_checks++;
        if (hit !== 0 || d !== 32'hBBBB_BBBB || ok !== 1) begin
            n_fail++;
            $display("FAIL evict_100: got hit=%b d=%h ok=%b required 0 bbbbbbbb 1", hit, d, ok);
        end
        access(32'h000, 2, 0, 0, hit, v, d, ok);
        model_fill(32'h000, 0);
        n_checks++;
        if (hit !== 0 || d !== 32'hAAAA_AAAA || ok !== 1) begin
            n_fail++;
            $display("FAIL refetch_000: got hit=%b d=%h ok=%b required 0 aaaaaaaa 1", hit, d, ok);
        end
    endtask

    task automatic test_flush();
        bit hit, v, ok; logic [31:0] d;
        // Flush one cycle into the miss: read continues in DRAIN, nothing forwarded.
        access(32'h20, 4, 1, 0, hit, v, d, ok);
        model_fill(32'h20, 0);
        n_checks++;
        if (hit !== 0 || v !== 0 || ok !== 1) begin
            n_fail++;
            $display("FAIL flush_drain: got hit=%b v=%b ok=%b required 0 0 1", hit, v, ok);
        end
        access(32'h20, 4, 0, 0, hit, v, d, ok);
        n_checks++;
        if (hit !== 1 || d !== mem_word(32'h20) || ok !== 1) begin
            n_fail++;
            $display("FAIL hit_after_drain: got hit=%b d=%h ok=%b required 1 %h 1", hit, d, ok, mem_word(32'h20));
        end
        access(32'h30, 3, 3, 0, hit, v, d, ok);
        model_fill(32'h30, 0);
        n_checks++;
        if (hit !== 0 || v !== 0 || ok !== 1) begin
            n_fail++;
            $display("FAIL flush_at_done: got hit=%b v=%b ok=%b required 0 0 1", hit, v, ok);
        end
        access(32'h30, 3, 0, 0, hit, v, d, ok);
        n_checks++;
        if (hit !== 1 || d !== mem_word(32'h30)) begin
            n_fail++;
            $display("FAIL hit_after_flush_done: got hit=%b d=%h required 1 %h", hit, d, mem_word(32'h30));
        end
    endtask

    task automatic test_inv_all();
        bit hit, v, ok, rd; logic [31:0] d;
        access(32'h10, 2, 0, 0, hit, v, d, ok);
        access(32'h14, 2, 0, 0, hit, v, d, ok);
        model_fill(32'h10, 0); model_fill(32'h14, 0);
        access(32'h14, 2, 0, 0, hit, v, d, ok);
        n_checks++;
        if (hit !== 1) begin
            n_fail++;
            $display("FAIL prefill_14: got hit=%b required 1", hit);
        end
        pulse_inv(1, 32'h10, v, rd);
        n_checks++;
        if (v !== 0 || rd !== 0) begin
            n_fail++;
            $display("FAIL inv_with_req: got v=%b next_read=%b required 0 0", v, rd);
        end
        access(32'h10, 2, 0, 0, hit, v, d, ok);
        model_fill(32'h10, 0);
        n_checks++;
        if (hit !== 0 || d !== mem_word(32'h10) || ok !== 1) begin
            n_fail++;
            $display("FAIL miss_10_after_inv: got hit=%b d=%h ok=%b required 0 %h 1", hit, d, ok, mem_word(32'h10));
        end
        access(32'h14, 2, 0, 0, hit, v, d, ok);
        model_fill(32'h14, 0);
        n_checks++;
        if (hit !== 0 || ok !== 1) begin
            n_fail++;
            $display("FAIL miss_14_after_inv: got hit=%b ok=%b required 0 1", hit, ok);
        end
        // inv_all in the done cycle: word forwarded, line left invalid, others cleared.
        access(32'h18, 3, 0, 1, hit, v, d, ok);
        model_fill(32'h18, 1);
        n_checks++;
        if (hit !== 0 || v !== 1 || d !== mem_word(32'h18) || ok !== 1) begin
            n_fail++;
            $display("FAIL inv_at_done: got hit=%b v=%b d=%h ok=%b required 0 1 %h 1", hit, v, d, ok, mem_word(32'h18));
        end
        access(32'h18, 2, 0, 0, hit, v, d, ok);
        model_fill(32'h18, 0);
        n_checks++;
        if (hit !== 0) begin
            n_fail++;
            $display("FAIL line_18_invalid: got hit=%b required 0", hit);
        end
        access(32'h10, 2, 0, 0, hit, v, d, ok);
        model_fill(32'h10, 0);
        n_checks++;
        if (hit !== 0) begin
            n_fail++;
            $display("FAIL line_10_cleared: got hit=%b required 0", hit);
        end
    endtask

    task automatic test_reset_mid_miss();
        bit hit, v, ok; logic [31:0] d;
        access(32'h44, 2, 0, 0, hit, v, d, ok);
        @(negedge clk);
        ifc.if_req = 1; ifc.if_addr = 32'h40;
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0; ifc.if_req = 0;
        #1;
        n_checks++;
        if (ifc.inst_read !== 0 || ifc.if_valid !== 0) begin
            n_fail++;
            $display("FAIL after_reset_mid_miss: got rd=%b v=%b required 0 0", ifc.inst_read, ifc.if_valid);
        end
        @(negedge clk);
        ifc.inst_done = 1; ifc.inst_data = 32'hDEAD_BEEF;
        #1;
        n_checks++;
        if (ifc.inst_read !== 0 || ifc.if_valid !== 0 || ifc.if_data !== 0) begin
            n_fail++;
            $display("FAIL stray_done: got rd=%b v=%b d=%h required 0 0 0", ifc.inst_read, ifc.if_valid, ifc.if_data);
        end
        @(negedge clk);
        idle_inputs();
        model_clear();
        access(32'h44, 2, 0, 0, hit, v, d, ok);
        model_fill(32'h44, 0);
        n_checks++;
        if (hit !== 0 || d !== mem_word(32'h44) || ok !== 1) begin
            n_fail++;
            $display("FAIL miss_after_reset: got hit=%b d=%h ok=%b required 0 %h 1", hit, d, ok, mem_word(32'h44));
        end
    endtask

    task automatic test_random();
        bit hit, v, ok, exp_hit, invd, rd, pv;
        logic [31:0] d, a;
        int lat, fc;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 24) == 0) pulse_inv($urandom_range(0, 1) == 1, 32'h8, pv, rd);
            a = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
            if ($urandom_range(0, 7) == 0) a[31] = 1'b1;
            lat  = $urandom_range(1, 5);
            fc   = ($urandom_range(0, 9) == 0) ? $urandom_range(1, lat) : 0;
            invd = ($urandom_range(0, 11) == 0);
            exp_hit = model_hit(a);
            access(a, lat, fc, invd, hit, v, d, ok);
            n_checks++;
            if (hit !== exp_hit || ok !== 1) begin
                n_fail++;
                $display("FAIL rand_lookup[%0d] addr=%h: got hit=%b ok=%b required %b 1", i, a, hit, ok, exp_hit);
            end
            n_checks++;
            if (exp_hit ? (d !== mem_word({a[31:2], 2'b00}))
                        : (v !== (fc == 0) || (fc == 0 && d !== mem_word({a[31:2], 2'b00})))) begin
                n_fail++;
                $display("FAIL rand_data[%0d] addr=%h: got v=%b d=%h required word %h", i, a, v, d, mem_word({a[31:2], 2'b00}));
            end
            if (!exp_hit) model_fill(a, invd);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
        $fatal(1);
    end

    initial begin
        idle_inputs();
        test_reset();
        test_cold_miss_hit();
        test_conflict();
        test_flush();
        test_inv_all();
        test_reset_mid_miss();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
